// File: rtl/vend_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : vend_ctrl_param
// Purpose  : Parametrised coin vending controller with credit accumulation,
//            vend/change handshakes and cancel-refund path.
// Revision : 1.0 - initial release
// ============================================================================
module vend_ctrl_param #(
   parameter int CREDIT_W   = 4,
   parameter int PRICE      = 3,
   parameter int VAL_A      = 1,
   parameter int VAL_B      = 2,
   parameter int VAL_C      = 4,
   parameter int MAX_CREDIT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          coin,
   input  logic                cancel,
   input  logic                vend_ack,
   input  logic                chg_ack,
   output logic                vend_valid,
   output logic                chg_valid,
   output logic                coin_rej,
   output logic                refund,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   localparam int SW = CREDIT_W + 1;
   localparam logic [SW-1:0]       C_VAL_A   = SW'(VAL_A);
   localparam logic [SW-1:0]       C_VAL_B   = SW'(VAL_B);
   localparam logic [SW-1:0]       C_VAL_C   = SW'(VAL_C);
   localparam logic [SW-1:0]       C_MAX     = SW'(MAX_CREDIT);
   localparam logic [SW-1:0]       C_PRICE_W = SW'(PRICE);
   localparam logic [CREDIT_W-1:0] C_PRICE   = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] C_ONE     = CREDIT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_VEND    = 2'd2,
      S_CHANGE  = 2'd3
   } state_t;

   if (PRICE > MAX_CREDIT) begin : g_chk_price
      $error("vend_ctrl_param: PRICE exceeds MAX_CREDIT");
   end
   if ((VAL_A > MAX_CREDIT) || (VAL_B > MAX_CREDIT) || (VAL_C > MAX_CREDIT)) begin : g_chk_val
      $error("vend_ctrl_param: coin value exceeds MAX_CREDIT");
   end
   if (MAX_CREDIT > (2 ** CREDIT_W) - 1) begin : g_chk_max
      $error("vend_ctrl_param: MAX_CREDIT does not fit in CREDIT_W");
   end

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                vend_valid_q, vend_valid_d;
   logic                chg_valid_q, chg_valid_d;
   logic                coin_rej_q, coin_rej_d;
   logic                refund_q, refund_d;
   logic                busy_q, busy_d;
   logic [SW-1:0]       val_w, sum_w;
   logic [CREDIT_W-1:0] rem_w;
   logic                coin_w;

   always_comb begin
      val_w = '0;
      case (coin)
         2'b01:   val_w = C_VAL_A;
         2'b10:   val_w = C_VAL_B;
         2'b11:   val_w = C_VAL_C;
         default: val_w = '0;
      endcase
   end

   assign coin_w = (coin != 2'b00);
   assign sum_w  = {1'b0, credit_q} + val_w;
   // VEND is only entered with credit >= PRICE, so this never underflows.
   assign rem_w  = credit_q - C_PRICE;

   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      refund_d   = refund_q;
      coin_rej_d = 1'b0;
      case (state_q)
         S_IDLE, S_COLLECT: begin
            if (coin_w) begin
               if (cancel || (sum_w > C_MAX)) begin
                  coin_rej_d = 1'b1;
               end else begin
                  credit_d = sum_w[CREDIT_W-1:0];
                  state_d  = (sum_w >= C_PRICE_W) ? S_VEND : S_COLLECT;
               end
            end
            if ((state_q == S_COLLECT) && cancel) begin
               state_d  = S_CHANGE;
               refund_d = 1'b1;
            end
         end
         S_VEND: begin
            coin_rej_d = coin_w;
            if (vend_ack) begin
               credit_d = rem_w;
               refund_d = 1'b0;
               state_d  = (rem_w != '0) ? S_CHANGE : S_IDLE;
            end
         end
         S_CHANGE: begin
            coin_rej_d = coin_w;
            if (chg_ack && (credit_q != '0)) begin
               credit_d = credit_q - C_ONE;
               if (credit_q == C_ONE) begin
                  state_d  = S_IDLE;
                  refund_d = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Outputs are registered, so they are derived from the next state.
      vend_valid_d = (state_d == S_VEND);
      chg_valid_d  = (state_d == S_CHANGE) && (credit_d != '0);
      busy_d       = (state_d == S_VEND) || (state_d == S_CHANGE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         credit_q     <= '0;
         vend_valid_q <= 1'b0;
         chg_valid_q  <= 1'b0;
         coin_rej_q   <= 1'b0;
         refund_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         credit_q     <= credit_d;
         vend_valid_q <= vend_valid_d;
         chg_valid_q  <= chg_valid_d;
         coin_rej_q   <= coin_rej_d;
         refund_q     <= refund_d;
         busy_q       <= busy_d;
      end
   end

   assign vend_valid = vend_valid_q;
   assign chg_valid  = chg_valid_q;
   assign coin_rej   = coin_rej_q;
   assign refund     = refund_q;
   assign credit     = credit_q;
   assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_ctrl_param
// Purpose  : Table, directed and randomized checks of vend_ctrl_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_ctrl_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] coin = 2'b00;
   logic       cancel = 1'b0, vend_ack = 1'b0, chg_ack = 1'b0;

   logic       vv0, cv0, rej0, ref0, busy0;
   logic [3:0] cr0;
   logic       vv1, cv1, rej1, ref1, busy1;
   logic [3:0] cr1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vend_ctrl_param u_dut0 (
      .clk(clk), .rst(rst), .coin(coin), .cancel(cancel),
      .vend_ack(vend_ack), .chg_ack(chg_ack),
      .vend_valid(vv0), .chg_valid(cv0), .coin_rej(rej0),
      .refund(ref0), .credit(cr0), .busy(busy0)
   );

   vend_ctrl_param #(.PRICE(14)) u_dut1 (
      .clk(clk), .rst(rst), .coin(coin), .cancel(cancel),
      .vend_ack(vend_ack), .chg_ack(chg_ack),
      .vend_valid(vv1), .chg_valid(cv1), .coin_rej(rej1),
      .refund(ref1), .credit(cr1), .busy(busy1)
   );

   typedef struct {
      bit       r;
      bit [1:0] c;
      bit       can, va, ca;
      int       e_cr;
      bit       e_vv, e_cv, e_rej, e_ref, e_busy;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r, input bit [1:0] c, input bit can, input bit va,
                      input bit ca, input int e_cr, input bit e_vv, input bit e_cv,
                      input bit e_rej, input bit e_ref, input bit e_busy);
      vec_t v;
      v = '{r, c, can, va, ca, e_cr, e_vv, e_cv, e_rej, e_ref, e_busy};
      tbl.push_back(v);
   endtask

   task automatic drive(input bit r, input bit [1:0] c, input bit can,
                        input bit va, input bit ca);
      @(negedge clk);
      rst = r; coin = c; cancel = can; vend_ack = va; chg_ack = ca;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input int sel, input int e_cr, input bit e_vv,
                        input bit e_cv, input bit e_rej, input bit e_ref, input bit e_busy);
      logic [8:0] act, exp;
      act = (sel == 1) ? {cr1, vv1, cv1, rej1, ref1, busy1}
                       : {cr0, vv0, cv0, rej0, ref0, busy0};
      exp = {4'(e_cr), e_vv, e_cv, e_rej, e_ref, e_busy};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got credit=%0d vv=%b cv=%b rej=%b ref=%b busy=%b, want credit=%0d vv=%b cv=%b rej=%b ref=%b busy=%b",
                  nm, act[8:5], act[4], act[3], act[2], act[1], act[0],
                  exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Reference model: credit as an integer plus "owed item" / "paying out" flags.
   int m_credit[2];
   bit m_owe_item[2], m_paying[2], m_ref[2], m_rej[2];
   int m_price[2] = '{3, 14};

   function automatic int coin_val(input bit [1:0] c);
      return (c == 2'd1) ? 1 : (c == 2'd2) ? 2 : (c == 2'd3) ? 4 : 0;
   endfunction

   task automatic model_step(input int k, input bit r, input bit [1:0] c,
                             input bit can, input bit va, input bit ca);
      m_rej[k] = 1'b0;
      if (r) begin
         m_credit[k] = 0; m_owe_item[k] = 0; m_paying[k] = 0; m_ref[k] = 0;
      end else if (m_owe_item[k]) begin
         m_rej[k] = (c != 0);
         if (va) begin
            m_credit[k] -= m_price[k];
            m_owe_item[k] = 0;
            m_paying[k] = (m_credit[k] > 0);
            m_ref[k] = 0;
         end
      end else if (m_paying[k]) begin
         m_rej[k] = (c != 0);
         if (ca && m_credit[k] > 0) begin
            m_credit[k] -= 1;
            if (m_credit[k] == 0) begin
               m_paying[k] = 0;
               m_ref[k] = 0;
            end
         end
      end else if (can) begin
         m_rej[k] = (c != 0);
         if (m_credit[k] > 0) begin
            m_paying[k] = 1;
            m_ref[k] = 1;
         end
      end else if (c != 0) begin
         if (m_credit[k] + coin_val(c) > 15) m_rej[k] = 1;
         else begin
            m_credit[k] += coin_val(c);
            if (m_credit[k] >= m_price[k]) m_owe_item[k] = 1;
         end
      end
   endtask

   initial begin
      // rst c  can va ca | cr vv cv rej ref busy
      add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
      // three A coins, vend held off then acked (cancel in VEND ignored)
      add(0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0,   2, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0,   3, 1, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0,   3, 1, 0, 0, 0, 1);
      add(0, 0, 1, 0, 0,   3, 1, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0,   3, 1, 0, 0, 0, 1);
      add(0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0);
      // B,B then vend leaves one unit of change
      add(0, 2, 0, 0, 0,   2, 0, 0, 0, 0, 0);
      add(0, 2, 0, 0, 0,   4, 1, 0, 0, 0, 1);
      add(0, 0, 0, 1, 0,   1, 0, 1, 0, 0, 1);
      add(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
      // C straight to VEND, coin during VEND rejected
      add(0, 3, 0, 0, 0,   4, 1, 0, 0, 0, 1);
      add(0, 1, 0, 0, 0,   4, 1, 0, 1, 0, 1);
      add(0, 0, 0, 0, 0,   4, 1, 0, 0, 0, 1);
      add(0, 2, 0, 1, 0,   1, 0, 1, 1, 0, 1);
      add(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
      // cancel wins over coin in COLLECT
      add(0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
      add(0, 2, 1, 0, 0,   1, 0, 1, 1, 1, 1);
      add(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
      // cancel+coin in IDLE, stray acks in IDLE
      add(0, 1, 1, 0, 0,   0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0);
      // reset mid-change
      add(0, 2, 0, 0, 0,   2, 0, 0, 0, 0, 0);
      add(0, 3, 0, 0, 0,   6, 1, 0, 0, 0, 1);
      add(0, 0, 0, 1, 0,   3, 0, 1, 0, 0, 1);
      add(0, 0, 0, 0, 1,   2, 0, 1, 0, 0, 1);
      add(1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0);

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].c, tbl[i].can, tbl[i].va, tbl[i].ca);
         check($sformatf("row%0d", i), 0, tbl[i].e_cr, tbl[i].e_vv, tbl[i].e_cv,
               tbl[i].e_rej, tbl[i].e_ref, tbl[i].e_busy);
      end

      // PRICE=14 instance: overflow rejection near the top of the credit range
      drive(1, 0, 0, 0, 0); check("p14_rst", 1, 0, 0, 0, 0, 0, 0);
      drive(0, 3, 0, 0, 0); check("p14_c1", 1, 4, 0, 0, 0, 0, 0);
      drive(0, 3, 0, 0, 0); check("p14_c2", 1, 8, 0, 0, 0, 0, 0);
      drive(0, 3, 0, 0, 0); check("p14_c3", 1, 12, 0, 0, 0, 0, 0);
      drive(0, 3, 0, 0, 0); check("p14_ovf", 1, 12, 0, 0, 1, 0, 0);
      drive(0, 2, 0, 0, 0); check("p14_b", 1, 14, 1, 0, 0, 0, 1);
      drive(0, 0, 0, 1, 0); check("p14_ack", 1, 0, 0, 0, 0, 0, 0);

      // randomized traffic against the reference model, both price settings
      drive(1, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) model_step(k, 1, 0, 0, 0, 0);
      for (int n = 0; n < 3000; n++) begin
         bit       r, can, va, ca;
         bit [1:0] c;
         r   = ($urandom_range(0, 299) == 0);
         c   = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
         can = ($urandom_range(0, 9) == 0);
         va  = ($urandom_range(0, 2) == 0);
         ca  = ($urandom_range(0, 1) == 0);
         drive(r, c, can, va, ca);
         for (int k = 0; k < 2; k++) begin
            model_step(k, r, c, can, va, ca);
            check($sformatf("rnd%0d_d%0d", n, k), k, m_credit[k], m_owe_item[k],
                  m_paying[k] && (m_credit[k] > 0), m_rej[k], m_ref[k],
                  m_owe_item[k] || m_paying[k]);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
